frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Per-frame controller in front of the header extractor and payload path of the Ethernet parser.
- Accepts one AXI-Stream input frame at a time and counts beats and bytes.
- Sequences the frame through header capture, payload forwarding and error drop.
- Emits one status record per frame: length, runt and oversize flags.

Parameters:
- DATA_WIDTH, 64, stream width in bits; must be a multiple of 8; BPB = DATA_WIDTH/8.
- HEADER_BYTES, 18, header length including the VLAN tag; HDR_BEATS = ceil(HEADER_BYTES/BPB).
- MIN_FRAME_BYTES, 60, frames shorter than this are flagged runt.
- MAX_FRAME_BYTES, 1522, frames longer than this are flagged oversize.
- LEN_W, $clog2(MAX_FRAME_BYTES+BPB)+1, width of the byte counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- s_tvalid  in  1  input beat valid.
- s_tdata  in  DATA_WIDTH  input beat data.
- s_tkeep  in  BPB  byte enables; honoured on the tlast beat only, all ones elsewhere.
- s_tlast  in  1  last beat of the frame.
- s_tready  out  1  input ready.
- hdr_we  out  1  header beat write strobe, equal to the accepted input beat in HEADER.
- hdr_beat_idx  out  $clog2(HDR_BEATS+1)  index of the header beat being written.
- header_done  out  1  one-cycle pulse after the last header beat is accepted.
- m_tvalid  out  1  payload beat valid.
- m_tdata  out  DATA_WIDTH  payload beat data.
- m_tkeep  out  BPB  payload byte enables.
- m_tlast  out  1  last payload beat.
- m_tready  in  1  downstream ready.
- stat_valid  out  1  one-cycle pulse carrying the frame status record.
- stat_len  out  LEN_W  frame byte count.
- stat_runt  out  1  runt flag.
- stat_oversize  out  1  oversize flag.

Behaviour:
- Reset: state IDLE, all counters 0. All outputs are 0 except s_tready=1.
- Beat accept = s_tvalid & s_tready. Byte count adds BPB per accepted beat, or popcount(s_tkeep) on the tlast beat. The count saturates at all ones.
- IDLE, s_tready=1:
  - An accepted beat starts the frame, is treated as header beat 0 (hdr_we=1, idx=0) and moves to HEADER.
  - If that beat also has tlast: go to STATUS, runt=1, no header_done.
- HEADER, s_tready=1:
  - Header beats are consumed, never forwarded. Each accepted beat strobes hdr_we and increments idx.
  - Header capture is beat-granular; residual bytes beyond HEADER_BYTES inside the last header beat belong to the extractor.
  - On acceptance of beat HDR_BEATS-1: header_done pulses the next cycle. Next state is PAYLOAD, or STATUS if tlast.
  - tlast before HDR_BEATS beats: runt=1, no header_done, go to STATUS.
- PAYLOAD:
  - Combinational pass-through: s_tready=m_tready, m_tvalid=s_tvalid, m_tdata/m_tkeep/m_tlast follow s_*.
  - Data is never dropped while m_tready=0.
  - On accept with tlast: go to STATUS.
  - On accept where the updated count exceeds MAX_FRAME_BYTES without tlast: that beat is forwarded with m_tlast forced to 1, oversize=1, go to DROP.
- DROP: s_tready=1, m_tvalid=0. Beats are discarded until tlast is accepted, then go to STATUS.
- STATUS, one cycle, s_tready=0:
  - stat_valid=1 with stat_len = final count.
  - runt = the header-phase runt condition OR len < MIN_FRAME_BYTES.
  - Then go to IDLE with counters cleared.
  - Back-to-back frame gap: minimum one idle cycle on the input.
- Header-only frame (exactly HDR_BEATS beats, last one tlast): header_done pulses and STATUS follows; no m_* beats are emitted.
- Simultaneous oversize and tlast on the same beat: forwarded with tlast, oversize=1, go to STATUS (no DROP).
- rst asserted mid-frame: immediate return to reset values. No stat_valid for the aborted frame. The bench restarts the input at a frame boundary.

Optional Feature:
- FRAME_SEQ_STATS_EN defined adds three outputs:
  - cnt_frames (32 bits): increments on every stat_valid.
  - cnt_runt (32 bits): increments on stat_valid with stat_runt=1.
  - cnt_oversize (32 bits): increments on stat_valid with stat_oversize=1.
- The counters wrap modulo 2^32 and reset to 0 on rst.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- 64-byte frame (8 beats, BPB=8, m_tready=1): hdr_we on beats 0-2, header_done 1 cycle after beat 2, 5 beats forwarded, last with m_tlast. Then stat_len=64, runt=0, oversize=0.
- 2-beat frame, tlast on beat 1: no header_done, no m_tvalid, stat_len=16, stat_runt=1.
- 200-beat frame with MAX_FRAME_BYTES=1522: beat 190 (count 1528) forwarded with m_tlast=1, beats 191-199 dropped with s_tready=1. Then stat_len=1600, stat_oversize=1.
- 64-byte frame with m_tready toggled 1-0-1 every cycle in PAYLOAD: s_tready mirrors m_tready, all 5 payload beats arrive in order unaltered, stat_len=64.
- Final beat s_tkeep=8'h0F on an otherwise 60-byte frame: stat_len=60, runt=0. Same frame with tkeep=8'h03: stat_len=58, runt=1.
- rst pulsed during PAYLOAD beat 4: outputs return to reset values at once, no stat_valid, next frame reports correctly.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame AXI-Stream controller (header capture, payload
// forwarding, oversize drop, one status record per frame).
// Optional: define FRAME_SEQ_STATS_EN for cnt_frames/cnt_runt/cnt_oversize.
module frame_sequencer #(
  parameter int DATA_WIDTH       = 64,
  parameter int HEADER_BYTES     = 18,
  parameter int MIN_FRAME_BYTES  = 60,
  parameter int MAX_FRAME_BYTES  = 1522,
  localparam int BPB             = DATA_WIDTH / 8,
  localparam int HDR_BEATS       = (HEADER_BYTES + BPB - 1) / BPB,
  localparam int LEN_W           = $clog2(MAX_FRAME_BYTES + BPB) + 1,
  localparam int IDX_W           = $clog2(HDR_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [BPB-1:0]        s_tkeep,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic                  hdr_we,
  output logic [IDX_W-1:0]      hdr_beat_idx,
  output logic                  header_done,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [BPB-1:0]        m_tkeep,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  stat_valid,
  output logic [LEN_W-1:0]      stat_len,
  output logic                  stat_runt,
  output logic                  stat_oversize
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [31:0]           cnt_frames,
  output logic [31:0]           cnt_runt,
  output logic [31:0]           cnt_oversize
`endif
);

  localparam logic [LEN_W-1:0] BPB_LEN  = LEN_W'(BPB);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME_BYTES);
  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DROP    = 3'd3,
    ST_STATUS  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt;
  logic [LEN_W-1:0]  count_r;
  logic [IDX_W-1:0]  idx_r;
  logic              runt_r;
  logic              oversize_r;
  logic              header_done_r;
  logic [LEN_W-1:0]  add_s;
  logic [LEN_W:0]    sum_s;
  logic [LEN_W-1:0]  next_count_s;
  logic              over_s;
  logic              accept_s;

  function automatic logic [LEN_W-1:0] popcount(input logic [BPB-1:0] keep);
    logic [LEN_W-1:0] c;
    c = '0;
    for (int i = 0; i < BPB; i++) begin
      c = c + LEN_W'(keep[i]);
    end
    return c;
  endfunction

  assign accept_s    = s_tvalid & s_tready;
  assign header_done = header_done_r;

  // Saturating byte count as it would be after accepting the current beat.
  always_comb begin
    if (s_tlast) begin
      add_s = popcount(s_tkeep);
    end else begin
      add_s = BPB_LEN;
    end
    sum_s = {1'b0, count_r} + {1'b0, add_s};
    if (sum_s[LEN_W]) begin
      next_count_s = '1;
    end else begin
      next_count_s = sum_s[LEN_W-1:0];
    end
    over_s = (next_count_s > MAX_LEN);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && s_tlast) begin
          state_nxt = ST_STATUS;
        end else if (accept_s) begin
          state_nxt = (HDR_BEATS == 1) ? ST_PAYLOAD : ST_HEADER;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (accept_s && s_tlast) begin
          state_nxt = ST_STATUS;
        end else if (accept_s && (idx_r == LAST_IDX)) begin
          state_nxt = ST_PAYLOAD;
        end else begin
          state_nxt = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s && s_tlast) begin
          state_nxt = ST_STATUS;
        end else if (accept_s && over_s) begin
          state_nxt = ST_DROP;
        end else begin
          state_nxt = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (accept_s && s_tlast) begin
          state_nxt = ST_STATUS;
        end else begin
          state_nxt = ST_DROP;
        end
      end
      ST_STATUS: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-frame counters and flags; cleared as the status record is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r       <= '0;
      idx_r         <= '0;
      runt_r        <= 1'b0;
      oversize_r    <= 1'b0;
      header_done_r <= 1'b0;
    end else begin
      header_done_r <= 1'b0;
      if (state_r == ST_STATUS) begin
        count_r    <= '0;
        idx_r      <= '0;
        runt_r     <= 1'b0;
        oversize_r <= 1'b0;
      end else if (accept_s) begin
        count_r <= next_count_s;
        case (state_r)
          ST_IDLE: begin
            idx_r <= IDX_W'(1);
            if (s_tlast) begin
              runt_r <= 1'b1;
            end else begin
              header_done_r <= (HDR_BEATS == 1);
            end
          end
          ST_HEADER: begin
            idx_r <= idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
              header_done_r <= 1'b1;
            end else begin
              runt_r <= s_tlast;
            end
          end
          ST_PAYLOAD: begin
            oversize_r <= over_s;
          end
          default: begin
            oversize_r <= oversize_r;
          end
        endcase
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Output decode; payload is a combinational pass-through.
  always_comb begin
    s_tready      = 1'b0;
    hdr_we        = 1'b0;
    hdr_beat_idx  = '0;
    m_tvalid      = 1'b0;
    m_tdata       = '0;
    m_tkeep       = '0;
    m_tlast       = 1'b0;
    stat_valid    = 1'b0;
    stat_len      = '0;
    stat_runt     = 1'b0;
    stat_oversize = 1'b0;
    case (state_r)
      ST_IDLE, ST_HEADER: begin
        s_tready     = 1'b1;
        hdr_we       = s_tvalid;
        hdr_beat_idx = idx_r;
      end
      ST_PAYLOAD: begin
        s_tready = m_tready;
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        m_tkeep  = s_tkeep;
        m_tlast  = s_tlast | over_s;
      end
      ST_DROP: begin
        s_tready = 1'b1;
      end
      ST_STATUS: begin
        stat_valid    = 1'b1;
        stat_len      = count_r;
        stat_runt     = runt_r | (count_r < MIN_LEN);
        stat_oversize = oversize_r;
      end
      default: begin
        s_tready = 1'b0;
      end
    endcase
  end

`ifdef FRAME_SEQ_STATS_EN
  // Free-running frame statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_frames   <= 32'd0;
      cnt_runt     <= 32'd0;
      cnt_oversize <= 32'd0;
    end else if (state_r == ST_STATUS) begin
      cnt_frames   <= cnt_frames + 32'd1;
      cnt_runt     <= cnt_runt + {31'd0, stat_runt};
      cnt_oversize <= cnt_oversize + {31'd0, stat_oversize};
    end else begin
      cnt_frames   <= cnt_frames;
    end
  end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: randomized frames against a
// byte-accounting reference model.
module tb_frame_sequencer;
  localparam int BPB  = 8;
  localparam int HDR  = 3;
  localparam int MAXB = 1522;
  localparam int MINB = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tlast, s_tready, m_tready;
  logic [63:0] s_tdata, m_tdata;
  logic [7:0]  s_tkeep, m_tkeep;
  logic        hdr_we, header_done, m_tvalid, m_tlast;
  logic [1:0]  hdr_beat_idx;
  logic        stat_valid, stat_runt, stat_oversize;
  logic [11:0] stat_len;
`ifdef FRAME_SEQ_STATS_EN
  logic [31:0] cnt_frames, cnt_runt, cnt_oversize;
  int tally_f = 0, tally_r = 0, tally_o = 0;
`endif

  frame_sequencer dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .hdr_we(hdr_we), .hdr_beat_idx(hdr_beat_idx), .header_done(header_done),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .stat_valid(stat_valid), .stat_len(stat_len), .stat_runt(stat_runt),
    .stat_oversize(stat_oversize)
`ifdef FRAME_SEQ_STATS_EN
    , .cnt_frames(cnt_frames), .cnt_runt(cnt_runt), .cnt_oversize(cnt_oversize)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [63:0] fd[$];
  int          n;
  logic [7:0]  lkeep;
  int          rmode;
  int          vgap;
  int          exp_len, exp_nfwd, fwd_last;
  bit          exp_runt, exp_ov, exp_hd;
  int          got_stat, got_hd, got_nfwd, got_len, err_flow, err_fwd;
  bit          got_runt, got_ov;

  function automatic int pc(input logic [7:0] k);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(k[i]);
    return c;
  endfunction

  // Build a random frame and derive its expected outcome from byte totals.
  task automatic build(input int nb, input logic [7:0] kk);
    int cum = 0;
    int ov = -1;
    fd.delete();
    for (int i = 0; i < nb; i++) fd.push_back({$urandom, $urandom});
    n = nb;
    lkeep = kk;
    for (int i = 0; i < nb; i++) begin
      cum += (i == nb - 1) ? pc(kk) : BPB;
      if (i >= HDR && ov < 0 && cum > MAXB) ov = i;
    end
    exp_len  = (cum > 4095) ? 4095 : cum;
    exp_ov   = (ov >= 0);
    fwd_last = exp_ov ? ov : nb - 1;
    exp_nfwd = (nb > HDR) ? fwd_last - HDR + 1 : 0;
    exp_runt = (nb < HDR) || (cum < MINB);
    exp_hd   = (nb >= HDR);
  endtask

  // Drive the current frame and record what the DUT does with it.
  task automatic run_frame(input int budget);
    int k = 0;
    int cyc = 0;
    int hd_due = -1;
    bit acc;
    got_stat = 0; got_hd = 0; got_nfwd = 0; got_len = -1;
    got_runt = 1'b0; got_ov = 1'b0; err_flow = 0; err_fwd = 0;
    while (got_stat == 0 && cyc < budget) begin
      @(posedge clk); #1;
      if (k < n) begin
        s_tvalid = (int'($urandom_range(99)) >= vgap);
        s_tdata  = fd[k];
        s_tkeep  = (k == n - 1) ? lkeep : 8'hFF;
        s_tlast  = (k == n - 1);
      end else begin
        s_tvalid = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tlast = 1'b0;
      end
      if (rmode == 0)      m_tready = 1'b1;
      else if (rmode == 1) m_tready = (cyc % 2 == 0);
      else                 m_tready = ($urandom_range(1) == 1);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      if (header_done) begin
        got_hd++;
        if (cyc != hd_due) err_flow++;
      end
      if (stat_valid) begin
        got_stat++; got_len = int'(stat_len); got_runt = stat_runt; got_ov = stat_oversize;
      end
      if (k >= n) begin
        if (m_tvalid !== 1'b0 || hdr_we !== 1'b0 || s_tready !== 1'b0) err_flow++;
      end else if (k < HDR) begin
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || stat_valid !== 1'b0 || hdr_we !== acc) err_flow++;
        if (acc && int'(hdr_beat_idx) != k) err_flow++;
        if (acc && k == HDR - 1) hd_due = cyc + 1;
      end else if (k <= fwd_last) begin
        if (s_tready !== m_tready || m_tvalid !== s_tvalid || hdr_we !== 1'b0 || stat_valid !== 1'b0) err_flow++;
        if (m_tvalid && m_tready) begin
          got_nfwd++;
          if (m_tdata !== fd[k] || m_tkeep !== s_tkeep || m_tlast !== (k == fwd_last)) err_fwd++;
        end
      end else begin
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || stat_valid !== 1'b0) err_flow++;
      end
      if (acc) k++;
      cyc++;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    if (stat_valid) got_stat++;
`ifdef FRAME_SEQ_STATS_EN
    tally_f++; tally_r += int'(exp_runt); tally_o += int'(exp_ov);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset s_tready got=%b exp=1", s_tready); end
    total++; if ({m_tvalid, m_tlast, hdr_we, header_done, stat_valid} !== 5'd0) begin bad++; $display("FAIL reset strobes got=%b exp=00000", {m_tvalid, m_tlast, hdr_we, header_done, stat_valid}); end
    total++; if (stat_len !== 12'd0 || m_tdata !== 64'd0) begin bad++; $display("FAIL reset data got=%0d/%h exp=0/0", stat_len, m_tdata); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    build(8, 8'hFF); rmode = 0; vgap = 0; run_frame(200);
    total++; if (got_stat !== 1) begin bad++; $display("FAIL basic stat_count got=%0d exp=1", got_stat); end
    total++; if (got_len !== 64) begin bad++; $display("FAIL basic stat_len got=%0d exp=64", got_len); end
    total++; if (got_runt !== 1'b0 || got_ov !== 1'b0) begin bad++; $display("FAIL basic flags got=%b%b exp=00", got_runt, got_ov); end
    total++; if (got_hd !== 1) begin bad++; $display("FAIL basic header_done got=%0d exp=1", got_hd); end
    total++; if (got_nfwd !== 5 || err_fwd !== 0) begin bad++; $display("FAIL basic payload got=%0d beats/%0d bad exp=5/0", got_nfwd, err_fwd); end
    total++; if (err_flow !== 0) begin bad++; $display("FAIL basic handshake got=%0d errors exp=0", err_flow); end
  endtask

  task automatic test_short_runt;
    build(2, 8'hFF); rmode = 0; vgap = 0; run_frame(100);
    total++; if (got_len !== 16 || got_runt !== 1'b1) begin bad++; $display("FAIL short len/runt got=%0d/%b exp=16/1", got_len, got_runt); end
    total++; if (got_hd !== 0 || got_nfwd !== 0) begin bad++; $display("FAIL short hd/fwd got=%0d/%0d exp=0/0", got_hd, got_nfwd); end
    total++; if (err_flow !== 0 || got_stat !== 1) begin bad++; $display("FAIL short flow got=%0d/%0d exp=0/1", err_flow, got_stat); end
  endtask

  task automatic test_header_only;
    build(3, 8'hFF); rmode = 0; vgap = 0; run_frame(100);
    total++; if (got_hd !== 1 || got_nfwd !== 0) begin bad++; $display("FAIL hdronly hd/fwd got=%0d/%0d exp=1/0", got_hd, got_nfwd); end
    total++; if (got_len !== 24 || got_runt !== 1'b1 || err_flow !== 0) begin bad++; $display("FAIL hdronly len/runt/flow got=%0d/%b/%0d exp=24/1/0", got_len, got_runt, err_flow); end
  endtask

  task automatic test_oversize;
    build(200, 8'hFF); rmode = 0; vgap = 0; run_frame(1000);
    total++; if (got_len !== 1600 || got_ov !== 1'b1) begin bad++; $display("FAIL oversize len/ov got=%0d/%b exp=1600/1", got_len, got_ov); end
    total++; if (got_nfwd !== 188 || err_fwd !== 0) begin bad++; $display("FAIL oversize payload got=%0d/%0d exp=188/0", got_nfwd, err_fwd); end
    total++; if (err_flow !== 0 || got_stat !== 1) begin bad++; $display("FAIL oversize flow got=%0d/%0d exp=0/1", err_flow, got_stat); end
    build(191, 8'h03); rmode = 0; vgap = 0; run_frame(1000);
    total++; if (got_len !== 1522 || got_ov !== 1'b0) begin bad++; $display("FAIL maxlen len/ov got=%0d/%b exp=1522/0", got_len, got_ov); end
    build(191, 8'hFF); rmode = 0; vgap = 0; run_frame(1000);
    total++; if (got_len !== 1528 || got_ov !== 1'b1 || got_nfwd !== 188) begin bad++; $display("FAIL ovlast len/ov/fwd got=%0d/%b/%0d exp=1528/1/188", got_len, got_ov, got_nfwd); end
    total++; if (err_flow !== 0 || err_fwd !== 0) begin bad++; $display("FAIL ovlast flow got=%0d/%0d exp=0/0", err_flow, err_fwd); end
  endtask

  task automatic test_backpressure;
    build(8, 8'hFF); rmode = 1; vgap = 0; run_frame(200);
    total++; if (got_nfwd !== 5 || err_fwd !== 0) begin bad++; $display("FAIL bp payload got=%0d/%0d exp=5/0", got_nfwd, err_fwd); end
    total++; if (got_len !== 64 || err_flow !== 0) begin bad++; $display("FAIL bp len/flow got=%0d/%0d exp=64/0", got_len, err_flow); end
  endtask

  task automatic test_tkeep;
    build(8, 8'h0F); rmode = 0; vgap = 0; run_frame(200);
    total++; if (got_len !== 60 || got_runt !== 1'b0) begin bad++; $display("FAIL keep0f len/runt got=%0d/%b exp=60/0", got_len, got_runt); end
    total++; if (err_fwd !== 0 || got_nfwd !== 5) begin bad++; $display("FAIL keep0f payload got=%0d/%0d exp=5/0", got_nfwd, err_fwd); end
    build(8, 8'h03); rmode = 0; vgap = 0; run_frame(200);
    total++; if (got_len !== 58 || got_runt !== 1'b1) begin bad++; $display("FAIL keep03 len/runt got=%0d/%b exp=58/1", got_len, got_runt); end
  endtask

  task automatic test_mid_reset;
    int seen = 0;
    build(8, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = fd[i]; s_tkeep = 8'hFF; s_tlast = 1'b0; m_tready = 1'b1;
    end
    @(negedge clk);
    total++; if (m_tvalid !== 1'b1 || m_tdata !== fd[4]) begin bad++; $display("FAIL midrst pre got=%b/%h exp=1/%h", m_tvalid, m_tdata, fd[4]); end
    #1;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0;
    #1;
    total++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin bad++; $display("FAIL midrst outputs got=%b/%b exp=1/0", s_tready, m_tvalid); end
    repeat (3) begin @(negedge clk); if (stat_valid) seen++; end
    rst = 1'b0;
    repeat (2) begin @(negedge clk); if (stat_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst stat_valid got=%0d exp=0", seen); end
`ifdef FRAME_SEQ_STATS_EN
    tally_f = 0; tally_r = 0; tally_o = 0;
`endif
    build(8, 8'hFF); rmode = 0; vgap = 0; run_frame(200);
    total++; if (got_len !== 64 || got_runt !== 1'b0 || got_nfwd !== 5) begin bad++; $display("FAIL midrst next got=%0d/%b/%0d exp=64/0/5", got_len, got_runt, got_nfwd); end
    total++; if (err_flow !== 0 || err_fwd !== 0) begin bad++; $display("FAIL midrst flow got=%0d/%0d exp=0/0", err_flow, err_fwd); end
  endtask

  task automatic test_random;
    logic [7:0] kk;
    int nb;
    for (int f = 0; f < 24; f++) begin
      nb = (f % 6 == 5) ? int'($urandom_range(200, 185)) : int'($urandom_range(40, 1));
      kk = 8'hFF;
      kk = kk >> $urandom_range(7, 0);
      build(nb, kk); rmode = 2; vgap = 25; run_frame(4000);
      total++; if (got_stat !== 1 || got_len !== exp_len) begin bad++; $display("FAIL rand%0d len got=%0d/%0d exp=1/%0d", f, got_stat, got_len, exp_len); end
      total++; if (got_runt !== exp_runt || got_ov !== exp_ov) begin bad++; $display("FAIL rand%0d flags got=%b%b exp=%b%b", f, got_runt, got_ov, exp_runt, exp_ov); end
      total++; if (got_hd !== int'(exp_hd) || got_nfwd !== exp_nfwd) begin bad++; $display("FAIL rand%0d hd/fwd got=%0d/%0d exp=%0d/%0d", f, got_hd, got_nfwd, exp_hd, exp_nfwd); end
      total++; if (err_flow !== 0 || err_fwd !== 0) begin bad++; $display("FAIL rand%0d flow got=%0d/%0d exp=0/0", f, err_flow, err_fwd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_runt();
    test_header_only();
    test_oversize();
    test_backpressure();
    test_tkeep();
    test_mid_reset();
    test_random();
`ifdef FRAME_SEQ_STATS_EN
    total++; if (int'(cnt_frames) != tally_f || int'(cnt_runt) != tally_r || int'(cnt_oversize) != tally_o) begin
      bad++; $display("FAIL stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", cnt_frames, cnt_runt, cnt_oversize, tally_f, tally_r, tally_o);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
